// File: rtl/adder_arbiter_if.sv
// Handshake bundle between requesters, the shared adder and adder_arbiter.
// rsp_ovf exists only when ADDER_ARB_OVF_EN is defined.
interface adder_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [WIDTH-1:0]       add_a;
    logic [WIDTH-1:0]       add_b;
    logic [WIDTH-1:0]       add_out;
    logic                   rsp_valid;
    logic [IDW-1:0]         rsp_id;
    logic [WIDTH-1:0]       rsp_data;
    logic                   rsp_ready;
`ifdef ADDER_ARB_OVF_EN
    logic                   rsp_ovf;

    modport master (
        output req_valid, req_a, req_b, add_out, rsp_ready,
        input  req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_data,
        input  rsp_ovf
    );

    modport slave (
        input  req_valid, req_a, req_b, add_out, rsp_ready,
        output req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_data,
        output rsp_ovf
    );
`else
    modport master (
        output req_valid, req_a, req_b, add_out, rsp_ready,
        input  req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, add_out, rsp_ready,
        output req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_data
    );
`endif
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin sharing of one combinational adder among N_REQ requesters.
// Define ADDER_ARB_OVF_EN to add the registered rsp_ovf output.
module adder_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    adder_arbiter_if.slave bus
);
    localparam int IDW = $clog2(N_REQ);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [IDW-1:0]   r_last;
    logic [IDW-1:0]   r_id;
    logic [IDW-1:0]   w_gnt;
    logic             w_found;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic [N_REQ-1:0] w_ready;

    // Scan upward from last+1, wrapping, so the previous winner goes last
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!w_found && bus.req_valid[(int'(r_last) + k) % N_REQ]) begin
                w_found = 1'b1;
                w_gnt   = IDW'((int'(r_last) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (rst_n && r_state == IDLE && w_found) begin
            w_ready[w_gnt] = 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_found) w_next = CALC;
            CALC:    w_next = RESP;
            RESP:    if (bus.rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last  <= IDW'(N_REQ - 1);
            r_id    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_a  <= bus.req_a[int'(w_gnt)*WIDTH +: WIDTH];
                        r_b  <= bus.req_b[int'(w_gnt)*WIDTH +: WIDTH];
                        r_id <= w_gnt;
                    end
                end
                CALC: begin
                    r_data  <= bus.add_out;
                    r_valid <= 1'b1;
                    r_last  <= r_id;
                end
                RESP: begin
                    if (bus.rsp_ready) r_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef ADDER_ARB_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (r_state == CALC) begin
            r_ovf <= (r_a[MSB] == r_b[MSB]) && (bus.add_out[MSB] != r_a[MSB]);
        end
    end

    assign bus.rsp_ovf = r_ovf;
`endif

    assign bus.req_ready = w_ready;
    assign bus.add_a     = r_a;
    assign bus.add_b     = r_b;
    assign bus.rsp_valid = r_valid;
    assign bus.rsp_id    = r_id;
    assign bus.rsp_data  = r_data;
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a behavioural adder.
// Define ADDER_ARB_OVF_EN to also check rsp_ovf.
module tb_adder_arbiter;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    adder_arbiter_if #(.N_REQ(4), .WIDTH(8)) bus ();

    adder_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    assign bus.add_out = bus.add_a + bus.add_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a,
                           input logic [7:0] b);
        bus.req_a[i*8 +: 8] = a;
        bus.req_b[i*8 +: 8] = b;
        bus.req_valid[i]    = 1'b1;
    endtask

    task automatic run_one(input string tag, input int i,
                           input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] sum, input logic ovf);
        set_req(i, a, b);
        #1;
        chk({tag, ".ready"}, bus.req_ready, 32'(1 << i));
        tick();
        bus.req_valid[i]    = 1'b0;
        bus.req_a[i*8 +: 8] = 8'hA5;
        bus.req_b[i*8 +: 8] = 8'h5A;
        chk({tag, ".calc_valid"}, bus.rsp_valid, 0);
        tick();
        chk({tag, ".valid"}, bus.rsp_valid, 1);
        chk({tag, ".id"}, bus.rsp_id, i);
        chk({tag, ".data"}, bus.rsp_data, sum);
`ifdef ADDER_ARB_OVF_EN
        chk({tag, ".ovf"}, bus.rsp_ovf, ovf);
`else
        if (ovf === 1'bx) $display("unused");
`endif
        bus.rsp_ready = 1'b1;
        tick();
        chk({tag, ".done"}, bus.rsp_valid, 0);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;

        #12;
        chk("rst.ready", bus.req_ready, 0);
        chk("rst.add_a", bus.add_a, 0);
        chk("rst.add_b", bus.add_b, 0);
        chk("rst.valid", bus.rsp_valid, 0);
        chk("rst.id", bus.rsp_id, 0);
        chk("rst.data", bus.rsp_data, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // single request, operands visible on the adder during CALC
        set_req(0, 8'h12, 8'h34);
        #1;
        chk("single.ready", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid[0] = 1'b0;
        bus.req_a[7:0]   = 8'hEE;
        chk("single.add_a", bus.add_a, 8'h12);
        chk("single.add_b", bus.add_b, 8'h34);
        chk("single.calc_ready", bus.req_ready, 0);
        tick();
        chk("single.valid", bus.rsp_valid, 1);
        chk("single.id", bus.rsp_id, 0);
        chk("single.data", bus.rsp_data, 8'h46);
        bus.rsp_ready = 1'b1;
        tick();
        chk("single.done", bus.rsp_valid, 0);
        bus.rsp_ready = 1'b0;

        // wrap/overflow on requester 3 so last ends at 3
        run_one("wrap0", 3, 8'hFF, 8'h02, 8'h01, 1'b0);
        run_one("wrap1", 3, 8'h7F, 8'h01, 8'h80, 1'b1);
        run_one("wrap2", 3, 8'h80, 8'h80, 8'h00, 1'b1);

        // contention: grants 0,1,2,3,0 exactly 3 cycles apart
        bus.req_a     = {8'h03, 8'h02, 8'h01, 8'h00};
        bus.req_b     = {4{8'h10}};
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("cont%0d.ready", k), bus.req_ready, 32'(1 << (k % 4)));
            tick();
            chk($sformatf("cont%0d.gap", k), bus.req_ready, 0);
            tick();
            chk($sformatf("cont%0d.id", k), bus.rsp_id, k % 4);
            chk($sformatf("cont%0d.data", k), bus.rsp_data, 8'h10 + (k % 4));
            tick();
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        tick();
        chk("cont.idle", bus.rsp_valid, 0);

        // backpressure on requester 1 with requester 2 waiting
        set_req(1, 8'h55, 8'h22);
        #1;
        chk("bp.ready", bus.req_ready, 4'b0010);
        tick();
        bus.req_valid[1] = 1'b0;
        tick();
        set_req(2, 8'h03, 8'h04);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("bp%0d.valid", k), bus.rsp_valid, 1);
            chk($sformatf("bp%0d.id", k), bus.rsp_id, 1);
            chk($sformatf("bp%0d.data", k), bus.rsp_data, 8'h77);
            chk($sformatf("bp%0d.ready", k), bus.req_ready, 0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("bp.released", bus.rsp_valid, 0);
        chk("bp.next_grant", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid[2] = 1'b0;
        tick();
        chk("bp.id2", bus.rsp_id, 2);
        chk("bp.data2", bus.rsp_data, 8'h07);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;

        // reset while requester 1 is in CALC
        set_req(1, 8'h01, 8'h01);
        tick();
        bus.req_valid[1] = 1'b0;
        chk("rmid.add_a", bus.add_a, 8'h01);
        rst_n = 1'b0;
        #1;
        chk("rmid.add_a0", bus.add_a, 0);
        chk("rmid.add_b0", bus.add_b, 0);
        chk("rmid.valid0", bus.rsp_valid, 0);
        chk("rmid.id0", bus.rsp_id, 0);
        set_req(0, 8'h21, 8'h02);
        set_req(2, 8'h33, 8'h01);
        #1;
        chk("rmid.ready0", bus.req_ready, 0);
        tick();
        tick();
        chk("rmid.noresp", bus.rsp_valid, 0);
        rst_n = 1'b1;
        #1;
        chk("rmid.prio", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid = '0;
        tick();
        chk("rmid.id", bus.rsp_id, 0);
        chk("rmid.data", bus.rsp_data, 8'h23);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;

        // late drop: requester 1 leaves before its turn, 2 is granted
        set_req(3, 8'h04, 8'h04);
        tick();
        bus.req_valid[3] = 1'b0;
        tick();
        set_req(1, 8'h11, 8'h11);
        set_req(2, 8'h20, 8'h02);
        #1;
        chk("drop.resp_ready", bus.req_ready, 0);
        chk("drop.data3", bus.rsp_data, 8'h08);
        tick();
        bus.req_valid[1] = 1'b0;
        bus.rsp_ready    = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("drop.grant", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid[2] = 1'b0;
        chk("drop.no1", bus.req_ready, 0);
        tick();
        chk("drop.id", bus.rsp_id, 2);
        chk("drop.data", bus.rsp_data, 8'h22);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin controller that shares the single combinational 8-bit `adder` in the MIPS datapath among up to `N_REQ` requesters, such as PC increment, branch-target and address-offset paths. It accepts operand pairs over a valid/ready handshake and sequences one addition at a time through the shared adder. It registers the sum and returns it, tagged with the requester ID, over a response handshake. It sits between the requesting pipeline units and the `adder` instance, and drives the adder's `a`/`b` inputs and samples its `out`.

## Interface
- `N_REQ`, default 4: number of requesters, range 2..8.
- `WIDTH`, default 8: operand/result width; must match `adder`.
- `IDW`, default `$clog2(N_REQ)`: requester-ID width (local parameter).
- `clk`: input, 1 bit. Single clock; all state changes on its rising edge.
- `rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `req_valid`: input, `N_REQ` bits. Per-requester operand-valid.
- `req_ready`: output, `N_REQ` bits. One-hot, single-cycle accept pulse.
- `req_a`: input, `N_REQ*WIDTH` bits. Operand A per requester; slice i is `[i*WIDTH +: WIDTH]`.
- `req_b`: input, `N_REQ*WIDTH` bits. Operand B per requester, same packing.
- `add_a`: output, `WIDTH` bits. Drives adder `a`.
- `add_b`: output, `WIDTH` bits. Drives adder `b`.
- `add_out`: input, `WIDTH` bits. Adder `out`, combinational sum.
- `rsp_valid`: output, 1 bit. Response valid.
- `rsp_id`: output, `IDW` bits. Index of the requester that owns the response.
- `rsp_data`: output, `WIDTH` bits. Registered sum.
- `rsp_ready`: input, 1 bit. The consumer accepts the response.

## Operation
- FSM states: IDLE, CALC, RESP.
- **IDLE**:
  - If any `req_valid` is set, grant the first set bit found scanning from `last+1` upward, wrapping modulo `N_REQ`.
  - Pulse `req_ready[g]` for this cycle only.
  - Latch `req_a`/`req_b` slice g into the operand registers and `g` into `rsp_id`.
  - Go to CALC.
  - If no `req_valid` is set, stay in IDLE.
- **CALC**:
  - `add_a`/`add_b` present the latched operands. They are registered outputs, updated on the grant edge.
  - Capture `add_out` into `rsp_data` and set `rsp_valid`.
  - Set `last` to `rsp_id`.
  - Go to RESP.
- **RESP**:
  - Hold `rsp_valid`, `rsp_id` and `rsp_data` stable until `rsp_ready` is high.
  - On that edge, clear `rsp_valid` and go to IDLE.
  - No new grant is made in RESP.
- Arithmetic: the sum is modulo 2^WIDTH. The adder provides no carry-out, and none is reported.
- A requester may drop `req_valid` before it is granted without side effects. Once `req_ready` has pulsed, the transaction is committed.
- Operands are sampled only on the grant edge. Changing `req_a`/`req_b` afterwards has no effect.
- `req_ready` is never asserted for a requester whose `req_valid` is low, and never outside IDLE.

## Timing
- Reset values:
  - State IDLE.
  - `req_ready`=0, `add_a`=0, `add_b`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0.
  - `last`=`N_REQ-1`, so requester 0 has first priority.
- Latency: with the grant edge at cycle T, `rsp_valid` rises at T+2.
- Throughput: with `rsp_ready` tied high, one operation per 3 cycles.
- A response accepted at edge E lets the next grant occur at E+1.
- `rsp_ready` high while `rsp_valid` is low is ignored.
- Asserting `rst_n` low in any state immediately clears all registers to their reset values. An in-flight transaction is dropped and no response is issued.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,N_REQ-1,0. Each requester waits at most `N_REQ-1` other transactions.

## Configuration
- `ADDER_ARB_OVF_EN` defined:
  - Adds output `rsp_ovf` (1 bit, reset 0), registered in CALC alongside `rsp_data`.
  - `rsp_ovf = (a[MSB]==b[MSB]) && (add_out[MSB]!=a[MSB])`, the two's-complement overflow of the latched operands.
  - It is held stable through RESP like the other response fields.
- `ADDER_ARB_OVF_EN` undefined: the `rsp_ovf` port and its logic are absent. All other behaviour is identical.

## Test plan
- **Single request:** requester 0 presents a=8'h12, b=8'h34 → `req_ready[0]` pulses at T; at T+2, `rsp_valid`=1, `rsp_id`=0, `rsp_data`=8'h46.
- **Wrap and overflow** (run with `ADDER_ARB_OVF_EN` defined):
  - 8'hFF+8'h02 → `rsp_data`=8'h01, `rsp_ovf`=0.
  - 8'h7F+8'h01 → `rsp_data`=8'h80, `rsp_ovf`=1.
  - 8'h80+8'h80 → `rsp_data`=8'h00, `rsp_ovf`=1.
- **Contention:** all four requesters are held valid with a=i, b=8'h10, and `rsp_ready`=1 → grants come 3 cycles apart in order 0,1,2,3,0, with `rsp_data` 8'h10, 8'h11, 8'h12, 8'h13.
- **Backpressure:** `rsp_ready`=0 for 5 cycles during RESP → `rsp_valid`/`rsp_id`/`rsp_data` remain constant and `req_ready` stays 0. The response completes on the first cycle `rsp_ready`=1, and the next grant occurs one cycle later.
- **Reset mid-operation:** pull `rst_n` low while in CALC → all outputs go to 0 asynchronously and no response appears. After release, requester 0 wins if requesters 0 and 2 are both valid.
- **Late drop:** requester 1 drops `req_valid` before it is granted while requester 2 stays valid → requester 2 is granted and `req_ready[1]` never asserts.
